// File: rtl/sort_job_scheduler_if.sv
// Request, sorter and response signals of sort_job_scheduler.
// The slave modport is the scheduler side. The master modport is the clients, sorter and consumer.
interface sort_job_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int W     = 16
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*8*W-1:0]   req_data;
   logic                   srt_en;
   logic [8*W-1:0]         srt_in;
   logic [8*W-1:0]         srt_out;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [8*W-1:0]         rsp_data;

   modport slave (
      input  req_valid, req_data, srt_out, rsp_ready,
      output req_ready, srt_en, srt_in, rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req_valid, req_data, srt_out, rsp_ready,
      input  req_ready, srt_en, srt_in, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/sort_job_scheduler.sv
// Round-robin scheduler sharing one 8-input sorter. SORT_JOB_SCHEDULER_STATS_EN adds job and busy counters.
// The result is valid SORT_LAT cycles after accept and held until rsp_ready. No grant is made until the response handshake.
module sort_job_scheduler #(
   parameter int N_REQ    = 4,
   parameter int W        = 16,
   parameter int SORT_LAT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   sort_job_scheduler_if.slave bus
`ifdef SORT_JOB_SCHEDULER_STATS_EN
   ,
   output logic [15:0]         jobs_done,
   output logic [31:0]         busy_cycles
`endif
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(SORT_LAT) + 1;
   localparam int DW    = 8 * W;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic              srt_en_q, srt_en_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     srt_in_q, srt_in_d;
   logic [DW-1:0]     rsp_data_q, rsp_data_d;

   logic              grant_vld;
   logic [ID_W-1:0]   grant;
   int                idx;

   // Scan offsets from high to low so the requester closest to rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      idx       = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (bus.req_valid[idx]) begin
            grant_vld = 1'b1;
            grant     = ID_W'(idx);
         end
      end
   end

   assign bus.req_ready = (rst_n && state_q == IDLE && grant_vld) ? (N_REQ'(1) << grant) : '0;
   assign bus.srt_en    = srt_en_q;
   assign bus.srt_in    = srt_in_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_id_d    = rsp_id_q;
      lat_cnt_d   = lat_cnt_q;
      srt_en_d    = srt_en_q;
      rsp_valid_d = rsp_valid_q;
      srt_in_d    = srt_in_q;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         IDLE: begin
            if (grant_vld) begin
               srt_in_d  = bus.req_data[int'(grant)*DW +: DW];
               rsp_id_d  = grant;
               rr_ptr_d  = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
               lat_cnt_d = '0;
               srt_en_d  = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            lat_cnt_d = lat_cnt_q + 1'b1;
            // The sorter's sticky done flag is not used; the result is timed by the counter alone.
            if (lat_cnt_q == CNT_W'(SORT_LAT - 1)) begin
               rsp_data_d  = bus.srt_out;
               rsp_valid_d = 1'b1;
               srt_en_d    = 1'b0;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         rsp_id_q    <= '0;
         lat_cnt_q   <= '0;
         srt_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         srt_in_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_id_q    <= rsp_id_d;
         lat_cnt_q   <= lat_cnt_d;
         srt_en_q    <= srt_en_d;
         rsp_valid_q <= rsp_valid_d;
         srt_in_q    <= srt_in_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef SORT_JOB_SCHEDULER_STATS_EN
   logic [15:0] jobs_done_q, jobs_done_d;
   logic [31:0] busy_cycles_q, busy_cycles_d;

   always_comb begin
      jobs_done_d   = jobs_done_q;
      busy_cycles_d = busy_cycles_q;
      if (state_q != IDLE) begin
         busy_cycles_d = busy_cycles_q + 32'd1;
      end
      if (state_q == RESP && bus.rsp_ready && jobs_done_q != 16'hFFFF) begin
         jobs_done_d = jobs_done_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jobs_done_q   <= '0;
         busy_cycles_q <= '0;
      end else begin
         jobs_done_q   <= jobs_done_d;
         busy_cycles_q <= busy_cycles_d;
      end
   end

   assign jobs_done   = jobs_done_q;
   assign busy_cycles = busy_cycles_q;
`endif
endmodule

// File: tb/tb_sort_job_scheduler.sv
// Randomized bench for sort_job_scheduler with a transaction-level reference model and a behavioural sorter.
// Define SORT_JOB_SCHEDULER_STATS_EN to also check the statistics counters.
module tb_sort_job_scheduler;
   localparam int N_REQ    = 4;
   localparam int W        = 16;
   localparam int SORT_LAT = 4;
   localparam int ID_W     = $clog2(N_REQ);
   localparam int DW       = 8 * W;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   sort_job_scheduler_if #(.N_REQ(N_REQ), .W(W)) bus();

`ifdef SORT_JOB_SCHEDULER_STATS_EN
   logic [15:0] jobs_done;
   logic [31:0] busy_cycles;
`endif

   sort_job_scheduler #(.N_REQ(N_REQ), .W(W), .SORT_LAT(SORT_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave)
`ifdef SORT_JOB_SCHEDULER_STATS_EN
      ,
      .jobs_done   (jobs_done),
      .busy_cycles (busy_cycles)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] sort8(input logic [DW-1:0] v);
      logic [W-1:0] e[8];
      logic [W-1:0] t;
      logic [DW-1:0] r;
      for (int k = 0; k < 8; k++) e[k] = v[k*W +: W];
      for (int a = 0; a < 7; a++)
         for (int b = 0; b < 7 - a; b++)
            if (e[b] > e[b+1]) begin
               t = e[b]; e[b] = e[b+1]; e[b+1] = t;
            end
      r = '0;
      for (int k = 0; k < 8; k++) r[k*W +: W] = e[k];
      return r;
   endfunction

   // Mix of wide values, small values (many duplicates) and all-equal vectors.
   function automatic logic [DW-1:0] rnd_vec();
      logic [DW-1:0] r;
      int kind;
      logic [W-1:0] same;
      kind = $urandom_range(0, 7);
      same = W'($urandom);
      for (int k = 0; k < 8; k++) begin
         if (kind == 0)      r[k*W +: W] = same;
         else if (kind < 4)  r[k*W +: W] = W'($urandom_range(0, 5));
         else                r[k*W +: W] = W'($urandom);
      end
      return r;
   endfunction

   // Reference model state: one job at a time, tracked as a transaction.
   int             cyc;
   bit             job_active;
   int             acc_cyc;
   logic [DW-1:0]  job_data;
   int             job_id;
   int             rr;
   int             grant_log[$];
   int             hs_count;
   logic [15:0]    exp_jobs;
   logic [31:0]    exp_busy;
   bit             rr_phase;
   bit             stats3_done;
   logic [ID_W-1:0] seen_id;
   logic [DW-1:0]  seen_data;

   // Stimulus state
   int             mode;      // 0 random, 1 all always valid, 2 only requester 2 with fixed data
   int             rsp_mode;  // 0 random, 1 always ready, 2 never ready
   bit             granted[N_REQ];
   logic [DW-1:0]  fixed_data;
   int             en_seen;

   function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
      for (int k = 0; k < N_REQ; k++)
         if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
      return -1;
   endfunction

   task automatic model_reset();
      job_active = 1'b0;
      job_data   = '0;
      rr         = 0;
      hs_count   = 0;
      exp_jobs   = '0;
      exp_busy   = '0;
      en_seen    = 0;
      grant_log.delete();
      for (int i = 0; i < N_REQ; i++) granted[i] = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_srt_en",    DW'(bus.srt_en),    '0);
      check_eq("rst_rsp_valid", DW'(bus.rsp_valid), '0);
      check_eq("rst_req_ready", DW'(bus.req_ready), '0);
      check_eq("rst_srt_in",    bus.srt_in,         '0);
      check_eq("rst_rsp_id",    DW'(bus.rsp_id),    '0);
      check_eq("rst_rsp_data",  bus.rsp_data,       '0);
`ifdef SORT_JOB_SCHEDULER_STATS_EN
      check_eq("rst_jobs_done",   DW'(jobs_done),   '0);
      check_eq("rst_busy_cycles", DW'(busy_cycles), '0);
`endif
      model_reset();
      repeat (2) @(posedge clk);
   endtask

   task automatic drive_inputs();
      logic [DW-1:0] d;
      if (bus.srt_en) begin
         bus.srt_out = (en_seen == SORT_LAT - 1) ? sort8(bus.srt_in) : rnd_vec();
         en_seen++;
      end else begin
         en_seen     = 0;
         bus.srt_out = rnd_vec();
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (mode == 2) begin
            if (i == 2 && !granted[i]) begin
               bus.req_valid[i] = 1'b1;
               bus.req_data[i*DW +: DW] = fixed_data;
            end else begin
               bus.req_valid[i] = 1'b0;
            end
         end else if (granted[i] || !bus.req_valid[i]) begin
            granted[i] = 1'b0;
            bus.req_valid[i] = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            d = rnd_vec();
            bus.req_data[i*DW +: DW] = d;
         end else if (mode == 0 && $urandom_range(0, 7) == 0) begin
            bus.req_valid[i] = 1'b0;
         end
      end
      case (rsp_mode)
         0:       bus.rsp_ready = ($urandom_range(0, 1) == 1);
         1:       bus.rsp_ready = 1'b1;
         default: bus.rsp_ready = 1'b0;
      endcase
   endtask

   task automatic step();
      int rel;
      int g;
      bit exp_en;
      bit exp_rv;
      logic [N_REQ-1:0] exp_rdy;
      @(negedge clk);
      rst_n = 1'b1;
      cyc++;
      rel    = cyc - acc_cyc;
      exp_en = job_active && rel >= 1 && rel <= SORT_LAT;
      exp_rv = job_active && rel > SORT_LAT;
      check_eq("srt_en",    DW'(bus.srt_en),    DW'(exp_en));
      check_eq("rsp_valid", DW'(bus.rsp_valid), DW'(exp_rv));
      check_eq("srt_in",    bus.srt_in,         job_data);
      if (exp_rv) begin
         check_eq("rsp_id",   DW'(bus.rsp_id), DW'(job_id));
         check_eq("rsp_data", bus.rsp_data,    sort8(job_data));
         seen_id   = bus.rsp_id;
         seen_data = bus.rsp_data;
      end
`ifdef SORT_JOB_SCHEDULER_STATS_EN
      check_eq("jobs_done",   DW'(jobs_done),   DW'(exp_jobs));
      check_eq("busy_cycles", DW'(busy_cycles), DW'(exp_busy));
      if (rr_phase && hs_count == 3 && !stats3_done) begin
         check_eq("three_jobs_done",   DW'(jobs_done),   DW'(3));
         check_eq("three_busy_cycles", DW'(busy_cycles), DW'(15));
         stats3_done = 1'b1;
      end
`endif
      drive_inputs();
      #1;
      exp_rdy = '0;
      g = -1;
      if (!job_active) begin
         g = pick(bus.req_valid, rr);
         if (g >= 0) exp_rdy[g] = 1'b1;
      end
      check_eq("req_ready", DW'(bus.req_ready), DW'(exp_rdy));
      // Advance the model across the coming clock edge.
      if (job_active) begin
         exp_busy++;
         if (exp_rv && bus.rsp_ready) begin
            job_active = 1'b0;
            hs_count++;
            if (exp_jobs != 16'hFFFF) exp_jobs++;
         end
      end else if (g >= 0) begin
         job_active = 1'b1;
         acc_cyc    = cyc;
         job_data   = bus.req_data[g*DW +: DW];
         job_id     = g;
         rr         = (g + 1) % N_REQ;
         granted[g] = 1'b1;
         grant_log.push_back(g);
      end
   endtask

   initial begin
      int t2_in[8]  = '{7, 3, 9, 1, 9, 0, 5, 2};
      int t2_out[8] = '{0, 1, 2, 3, 5, 7, 9, 9};
      logic [DW-1:0] t2_exp;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.srt_out   = '0;
      bus.rsp_ready = 1'b0;
      cyc = 0; acc_cyc = 0; job_id = 0;
      rr_phase = 1'b0; stats3_done = 1'b0;
      seen_id = '0; seen_data = '0;
      mode = 0; rsp_mode = 1;
      do_reset();

      // Single job from requester 2.
      for (int k = 0; k < 8; k++) begin
         fixed_data[k*W +: W] = W'(t2_in[k]);
         t2_exp[k*W +: W]     = W'(t2_out[k]);
      end
      mode = 2;
      for (int i = 0; i < 40 && hs_count < 1; i++) step();
      check_eq("single_done",  DW'(hs_count >= 1), DW'(1));
      check_eq("single_grant", DW'(grant_log.size() > 0 ? grant_log[0] : -1), DW'(2));
      check_eq("single_id",    DW'(seen_id), DW'(2));
      check_eq("single_data",  seen_data, t2_exp);

      // Response backpressure with every requester waiting.
      mode = 1; rsp_mode = 2;
      for (int i = 0; i < 20 && !bus.rsp_valid; i++) step();
      check_eq("bp_rsp_seen", DW'(bus.rsp_valid), DW'(1));
      repeat (10) step();
      rsp_mode = 1;
      repeat (6) step();

      // Random traffic.
      mode = 0; rsp_mode = 0;
      repeat (1500) step();

      // Asynchronous reset in the middle of a sort.
      mode = 1; rsp_mode = 1;
      for (int i = 0; i < 60 && !(job_active && cyc - acc_cyc == 2); i++) step();
      check_eq("mid_busy_reached", DW'(job_active), DW'(1));
      do_reset();

      // Round-robin order from requester 0 with all requesters valid.
      rr_phase = 1'b1;
      for (int i = 0; i < 200 && grant_log.size() < 6; i++) step();
      for (int k = 0; k < 6; k++)
         check_eq($sformatf("rr_order_%0d", k),
                  DW'(k < grant_log.size() ? grant_log[k] : -1), DW'(k % N_REQ));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
